// File: rtl/clk_div_monitor_if.sv
// Control/status bundle between the pin wrapper and clk_div_monitor.
// The wrapper drives div_in, ena and clear, and reads back the per-channel status.
interface clk_div_monitor_if #(
  parameter int NUM_CH = 4
);
  logic              ena;
  logic              clear;
  logic [NUM_CH-1:0] div_in;
  logic [NUM_CH-1:0] locked;
  logic [NUM_CH-1:0] fault;
  logic              all_locked;

  modport master (output ena, clear, div_in, input locked, fault, all_locked);
  modport slave  (input ena, clear, div_in, output locked, fault, all_locked);
endinterface

// File: rtl/clk_div_monitor.sv
// Checks that each divided-clock input toggles with a half-period of exactly 2^i clk cycles.
// Reports per-channel lock and sticky fault status.
module clk_div_monitor #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 4,
  parameter int LOCK_EDGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  clk_div_monitor_if.slave bus
);
  // state     | meaning
  // ST_IDLE   | waiting for the first edge
  // ST_TRACK  | counting on-time half-periods toward lock
  // ST_LOCKED | every half-period on time
  // ST_FAULT  | early, late or stuck input seen; held until clear
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam int GOOD_W = $clog2(LOCK_EDGES + 1);

  logic [NUM_CH-1:0] locked_v;
  logic [NUM_CH-1:0] fault_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CNT_W:0] EXP = (CNT_W+1)'(1) << i;

    logic              s1, s2, s3;
    logic [CNT_W-1:0]  cnt;
    logic [GOOD_W-1:0] good;
    state_t            state;

    logic              edge_det;
    logic [CNT_W:0]    meas;
    logic              on_time;
    logic              late;
    logic [CNT_W-1:0]  cnt_inc;
    logic [GOOD_W-1:0] good_inc;
    logic              lock_reached;

    // meas is the half-period length if an edge arrives this cycle
    assign edge_det     = s2 ^ s3;
    assign meas         = {1'b0, cnt} + (CNT_W+1)'(1);
    assign on_time      = (meas == EXP);
    assign late         = (meas >= EXP);
    assign cnt_inc      = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    assign good_inc     = good + GOOD_W'(1);
    assign lock_reached = (good_inc == GOOD_W'(LOCK_EDGES));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        s3    <= 1'b0;
        cnt   <= '0;
        good  <= '0;
        state <= ST_IDLE;
      end else begin
        s1 <= bus.div_in[i];
        s2 <= s1;
        s3 <= s2;
        if (!bus.ena) begin
          state <= ST_IDLE;
          cnt   <= '0;
          good  <= '0;
        end else if (bus.clear && (state == ST_FAULT)) begin
          state <= ST_IDLE;
          cnt   <= '0;
          good  <= '0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (edge_det) begin
                state <= ST_TRACK;
                cnt   <= '0;
                good  <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end
            ST_TRACK, ST_LOCKED: begin
              if (edge_det) begin
                cnt <= '0;
                if (!on_time) begin
                  state <= ST_FAULT;
                end else if (state == ST_TRACK) begin
                  good <= good_inc;
                  if (lock_reached) state <= ST_LOCKED;
                end
              end else if (late) begin
                state <= ST_FAULT;
              end else begin
                cnt <= cnt_inc;
              end
            end
            default: cnt <= cnt_inc;
          endcase
        end
      end
    end

    assign locked_v[i] = (state == ST_LOCKED);
    assign fault_v[i]  = (state == ST_FAULT);
  end

  assign bus.locked     = locked_v;
  assign bus.fault      = fault_v;
  assign bus.all_locked = &locked_v;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: per-channel toggle generators plus a timestamp-based
// reference model of lock/fault status.
module tb_clk_div_monitor;
  localparam int NUM_CH     = 4;
  localparam int LOCK_EDGES = 4;
  localparam int M_IDLE = 0, M_TRACK = 1, M_LOCKED = 2, M_FAULT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // generator: channel c toggles every gen_hp[c] cycles, 0 means hold
  int gen_hp[NUM_CH];
  int gen_ph[NUM_CH];

  clk_div_monitor_if #(.NUM_CH(NUM_CH)) bus();

  clk_div_monitor #(.NUM_CH(NUM_CH), .CNT_W(4), .LOCK_EDGES(LOCK_EDGES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference model: pin samples delayed two cycles, half-periods from edge timestamps
  logic [NUM_CH-1:0] hist[$];
  int cyc = 0;
  int m_mode[NUM_CH];
  int m_last[NUM_CH];
  int m_good[NUM_CH];
  logic [NUM_CH-1:0] m_locked = '0;
  logic [NUM_CH-1:0] m_fault  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      repeat (3) hist.push_back('0);
      for (int c = 0; c < NUM_CH; c++) begin
        m_mode[c] = M_IDLE;
        m_good[c] = 0;
        m_last[c] = 0;
      end
    end else begin
      cyc++;
      hist.push_front(bus.div_in);
      for (int c = 0; c < NUM_CH; c++) begin
        bit ev;
        int el;
        ev = (hist[2][c] != hist[3][c]);
        el = cyc - m_last[c];
        if (!bus.ena) begin
          m_mode[c] = M_IDLE;
          m_good[c] = 0;
        end else if (bus.clear && m_mode[c] == M_FAULT) begin
          m_mode[c] = M_IDLE;
          m_good[c] = 0;
        end else if (m_mode[c] == M_IDLE) begin
          if (ev) begin
            m_mode[c] = M_TRACK;
            m_good[c] = 0;
            m_last[c] = cyc;
          end
        end else if (m_mode[c] != M_FAULT) begin
          if (ev) begin
            if (el != (1 << c)) m_mode[c] = M_FAULT;
            else if (m_mode[c] == M_TRACK) begin
              m_good[c]++;
              if (m_good[c] == LOCK_EDGES) m_mode[c] = M_LOCKED;
            end
            m_last[c] = cyc;
          end else if (el >= (1 << c)) begin
            m_mode[c] = M_FAULT;
          end
        end
      end
      hist.pop_back();
    end
    for (int c = 0; c < NUM_CH; c++) begin
      m_locked[c] = (m_mode[c] == M_LOCKED);
      m_fault[c]  = (m_mode[c] == M_FAULT);
    end
  end

  task automatic drive_next();
    for (int c = 0; c < NUM_CH; c++) begin
      if (gen_hp[c] > 0) begin
        gen_ph[c]++;
        if (gen_ph[c] >= gen_hp[c]) begin
          gen_ph[c] = 0;
          bus.div_in[c] = ~bus.div_in[c];
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.ena = 1'b1;
    bus.clear = 1'b0;
    bus.div_in = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      gen_hp[c] = 1 << c;
      gen_ph[c] = 0;
    end
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.locked !== 4'b0000 || bus.fault !== 4'b0000 || bus.all_locked !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: locked=%b fault=%b all=%b want 0000 0000 0", bus.locked, bus.fault, bus.all_locked);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ideal_lock();
    int lock3_at = 0;
    int fault_seen = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      total++;
      if (bus.locked !== m_locked || bus.fault !== m_fault || bus.all_locked !== (&m_locked)) begin
        bad++;
        $display("FAIL ideal_model: locked=%b fault=%b all=%b want %b %b %b", bus.locked, bus.fault, bus.all_locked, m_locked, m_fault, &m_locked);
      end
      if (bus.locked[3] && lock3_at == 0) lock3_at = n;
      if (bus.fault != '0) fault_seen++;
      drive_next();
    end
    // ch3 toggles on drives 8,16,..,40; 5th edge shows up three negedges later
    total++;
    if (lock3_at !== 43) begin
      bad++;
      $display("FAIL ideal_lock3_time: got=%0d want=43", lock3_at);
    end
    total++;
    if (bus.locked !== 4'b1111 || bus.all_locked !== 1'b1 || fault_seen !== 0) begin
      bad++;
      $display("FAIL ideal_final: locked=%b all=%b fault_cycles=%0d want 1111 1 0", bus.locked, bus.all_locked, fault_seen);
    end
  endtask

  task automatic test_ena_drop();
    @(negedge clk);
    bus.clear = 1'b1;
    drive_next();
    @(negedge clk);
    total++;
    if (bus.locked !== 4'b1111 || bus.fault !== 4'b0000) begin
      bad++;
      $display("FAIL clear_when_locked: locked=%b fault=%b want 1111 0000", bus.locked, bus.fault);
    end
    bus.ena = 1'b0;
    drive_next();
    @(negedge clk);
    total++;
    if (bus.locked !== 4'b0000 || bus.fault !== 4'b0000 || bus.all_locked !== 1'b0) begin
      bad++;
      $display("FAIL ena_drop: locked=%b fault=%b all=%b want 0000 0000 0", bus.locked, bus.fault, bus.all_locked);
    end
    bus.ena = 1'b1;
    bus.clear = 1'b0;
    drive_next();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      total++;
      if (bus.locked !== m_locked || bus.fault !== m_fault || bus.all_locked !== (&m_locked)) begin
        bad++;
        $display("FAIL ena_model: locked=%b fault=%b all=%b want %b %b %b", bus.locked, bus.fault, bus.all_locked, m_locked, m_fault, &m_locked);
      end
      drive_next();
    end
    total++;
    if (bus.locked !== 4'b1111) begin
      bad++;
      $display("FAIL ena_relock: locked=%b want 1111", bus.locked);
    end
  endtask

  task automatic test_stuck();
    bit found = 0;
    bit prev;
    bit seen = 0;
    int n = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      prev = bus.div_in[2];
      drive_next();
      if (!prev && bus.div_in[2]) begin
        found = 1;
        gen_hp[2] = 0;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL stuck_setup: no rising toggle on ch2 within 40 cycles");
    end
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      total++;
      if (bus.locked !== m_locked || bus.fault !== m_fault || bus.all_locked !== (&m_locked)) begin
        bad++;
        $display("FAIL stuck_model: locked=%b fault=%b all=%b want %b %b %b", bus.locked, bus.fault, bus.all_locked, m_locked, m_fault, &m_locked);
      end
      seen = bus.fault[2];
      drive_next();
    end
    total++;
    if (n !== 7 || bus.fault !== 4'b0100 || bus.locked !== 4'b1011 || bus.all_locked !== 1'b0) begin
      bad++;
      $display("FAIL stuck_fault: after=%0d fault=%b locked=%b all=%b want 7 0100 1011 0", n, bus.fault, bus.locked, bus.all_locked);
    end
  endtask

  task automatic test_bad_period();
    gen_hp[1] = 3;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      total++;
      if (bus.locked !== m_locked || bus.fault !== m_fault || bus.all_locked !== (&m_locked)) begin
        bad++;
        $display("FAIL period3_model: locked=%b fault=%b all=%b want %b %b %b", bus.locked, bus.fault, bus.all_locked, m_locked, m_fault, &m_locked);
      end
      drive_next();
    end
    total++;
    if (bus.fault !== 4'b0110 || bus.locked !== 4'b1001 || bus.all_locked !== 1'b0) begin
      bad++;
      $display("FAIL period3_fault: fault=%b locked=%b all=%b want 0110 1001 0", bus.fault, bus.locked, bus.all_locked);
    end
  endtask

  task automatic test_clear();
    gen_hp[1] = 2;
    gen_hp[2] = 4;
    repeat (20) begin
      @(negedge clk);
      drive_next();
    end
    @(negedge clk);
    bus.clear = 1'b1;
    drive_next();
    @(negedge clk);
    total++;
    if (bus.fault !== 4'b0000 || bus.locked !== 4'b1001) begin
      bad++;
      $display("FAIL clear_pulse: fault=%b locked=%b want 0000 1001", bus.fault, bus.locked);
    end
    bus.clear = 1'b0;
    drive_next();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      total++;
      if (bus.locked !== m_locked || bus.fault !== m_fault || bus.all_locked !== (&m_locked)) begin
        bad++;
        $display("FAIL clear_model: locked=%b fault=%b all=%b want %b %b %b", bus.locked, bus.fault, bus.all_locked, m_locked, m_fault, &m_locked);
      end
      drive_next();
    end
    total++;
    if (bus.locked !== 4'b1111 || bus.all_locked !== 1'b1) begin
      bad++;
      $display("FAIL clear_relock: locked=%b all=%b want 1111 1", bus.locked, bus.all_locked);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.locked !== 4'b0000 || bus.fault !== 4'b0000 || bus.all_locked !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: locked=%b fault=%b all=%b want 0000 0000 0", bus.locked, bus.fault, bus.all_locked);
    end
    // the divider restarts from zero alongside the monitor
    for (int c = 0; c < NUM_CH; c++) begin
      gen_hp[c] = 1 << c;
      gen_ph[c] = 0;
    end
    bus.div_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      total++;
      if (bus.locked !== m_locked || bus.fault !== m_fault || bus.all_locked !== (&m_locked)) begin
        bad++;
        $display("FAIL reset_mid_model: locked=%b fault=%b all=%b want %b %b %b", bus.locked, bus.fault, bus.all_locked, m_locked, m_fault, &m_locked);
      end
      drive_next();
    end
    total++;
    if (bus.locked !== 4'b1111 || bus.all_locked !== 1'b1) begin
      bad++;
      $display("FAIL reset_recover: locked=%b all=%b want 1111 1", bus.locked, bus.all_locked);
    end
  endtask

  task automatic test_random();
    int c;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      total++;
      if (bus.locked !== m_locked || bus.fault !== m_fault || bus.all_locked !== (&m_locked)) begin
        bad++;
        $display("FAIL random_model: cycle=%0d locked=%b fault=%b all=%b want %b %b %b", n, bus.locked, bus.fault, bus.all_locked, m_locked, m_fault, &m_locked);
      end
      bus.ena   = ($urandom_range(0, 39) != 0);
      bus.clear = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0) begin
        c = $urandom_range(0, NUM_CH - 1);
        gen_hp[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : (1 << c);
      end
      drive_next();
    end
    bus.ena = 1'b1;
    bus.clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ideal_lock();
    test_ena_drop();
    test_stuck();
    test_bad_period();
    test_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Receive-side checker for the clock-divider outputs (div2, div4, div8, div16) produced elsewhere on the chip. The block samples up to four external divided-clock signals, measures every half-period in `clk` cycles, and reports per-channel lock and fault status. It sits at the top-level pin wrapper, fed from `ui_in`, with status driven to `uo_out`. It is used to prove on silicon, or in a loop-back board test, that a divider chain toggles at the exact expected ratios.

## Interface

Parameters:
- `NUM_CH`, default 4: number of monitored channels. Channel i expects a half-period of 2^i cycles.
- `CNT_W`, default 4: half-period counter width. Must satisfy 2^CNT_W > 2^(NUM_CH-1).
- `LOCK_EDGES`, default 4: consecutive correct half-periods required to declare lock.

Ports:
- `clk`, input, 1: the single clock. All logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `ena`, input, 1: when low, all channels are held in IDLE and all counters are cleared.
- `clear`, input, 1: synchronous, single-cycle. Returns FAULT channels to IDLE.
- `div_in`, input, NUM_CH: asynchronous divided-clock inputs. Bit i is the div-2^(i+1) signal.
- `locked`, output, NUM_CH: channel i is in LOCKED.
- `fault`, output, NUM_CH: channel i is in FAULT (sticky).
- `all_locked`, output, 1: AND of all `locked` bits.

## Operation

- Each channel has a 2-flop synchronizer (s1, s2), then a history flop s3. An edge is detected when s2 != s3. Rising and falling edges are treated the same.
- Per-channel `cnt` counts edge-free cycles since the last edge:
  - Cleared to 0 on an edge; otherwise incremented.
  - Saturates at 2^CNT_W-1.
  - Measured half-period = cnt+1. EXP_i = 2^i.
- Per-channel `good` counter runs 0..LOCK_EDGES.
- FSM per channel:
  - IDLE: first edge → TRACK, cnt=0, good=0.
  - TRACK, edge with cnt+1 == EXP_i: good++. If good reaches LOCK_EDGES → LOCKED.
  - TRACK, edge with cnt+1 != EXP_i (early): → FAULT.
  - TRACK, no edge with cnt+1 >= EXP_i (late or stuck): → FAULT.
  - LOCKED: applies the same early/late checks. Any violation → FAULT. Otherwise stays LOCKED.
  - FAULT: stays until `clear` or reset. `clear` → IDLE, cnt=0, good=0.
- Simultaneous events, in priority order:
  - `ena` low beats `clear`, which beats edge processing.
  - `clear` in a non-FAULT state is ignored.
- Channels are fully independent. A fault on one channel never affects another.
- Outputs are decoded directly from registered state, with no combinational path from `div_in`.

## Timing

- Reset values:
  - s1/s2/s3 = 0, cnt = 0, good = 0, state = IDLE.
  - `locked` = 0, `fault` = 0, `all_locked` = 0.
- Latency:
  - A pin transition captured by s1 at rising edge k is processed (state/cnt update) at edge k+2.
  - Status outputs change at that same edge.
- The synchronizer delay is constant, so measured half-periods are unaffected by it.
- For channel 0 (EXP=1), an edge must be detected on every cycle. One missing edge → FAULT on that cycle.
- Lock time for an ideal input: LOCK_EDGES+1 edges after leaving reset. The first edge only enters TRACK.
- Reset asserted mid-operation clears everything immediately. Deassertion resumes in IDLE on the next rising edge.
- `ena` low for one cycle clears cnt/good and forces IDLE. Re-lock then requires LOCK_EDGES+1 fresh edges.
- Counter saturation never wraps. It can only be reached while IDLE or FAULT, where it is don't-care.

## Test plan

- Ideal divider (div_in driven from a reference /2,/4,/8,/16 counter on `clk`) → `locked`=4'b1111 and `all_locked`=1. Channel 3 is the last to lock, after its 5th edge plus 2 cycles. `fault` stays 0 for 200 cycles.
- After lock, hold div_in[2] stuck at 1 → `fault`=4'b0100 exactly 4 cycles after the last edge is processed. `locked`=4'b1011, `all_locked`=0.
- Drive div_in[1] with half-period 3 instead of 2 → `fault[1]`=1 at the cnt+1==2 no-edge cycle. Other bits are unaffected.
- Pulse `clear` for 1 cycle with a now-correct div_in[1] → `fault[1]`=0 next cycle, then `locked[1]`=1 after 5 edges.
- Assert `rst_n`=0 asynchronously mid-lock → all outputs 0 immediately (before the next `clk` edge). They recover to all-locked after release.
- Drop `ena` for 1 cycle while locked → `locked`=0 next edge. They re-assert after LOCK_EDGES+1 edges per channel. Same-cycle `clear` has no effect.
